// File: rtl/partoserial_arb.sv
// Round-robin slot scheduler feeding one byte per 8-cycle slot to a shared serializer.
// Optional skip-symbol insertion is built only when SKP_INSERT_EN is defined.
module partoserial_arb #(
  parameter int         NUM_REQ      = 4,
  parameter int         INIT_SLOTS   = 4,
  parameter logic [7:0] IDLE_SYM     = 8'hBC,
  parameter logic [7:0] SKP_SYM      = 8'h1C,
  parameter int         SKP_INTERVAL = 64,
  localparam int        IDW          = $clog2(NUM_REQ)
) (
  input  logic                 clk_8f,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [7:0]           ser_data,
  output logic                 ser_valid,
  output logic                 slot_start,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  // Handshake: a requester holds req_valid and req_data stable until it sees its
  // req_ack pulse (bit_cnt==0 of the granted slot); it may then change or drop them.
  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [2:0]           bit_cnt;
  logic [3:0]           init_cnt, init_cnt_nxt;
  logic [IDW-1:0]       rr_ptr, rr_nxt, gid_nxt, pick, cand;
  logic [7:0]           data_nxt;
  logic                 valid_nxt, found, boundary, skp_due;
  logic [NUM_REQ-1:0]   ack_nxt;

  assign boundary  = (bit_cnt == 3'd7);
  assign busy      = ser_valid;
  assign dbg_state = state;

`ifdef SKP_INSERT_EN
  logic [7:0] slot_cnt;

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      slot_cnt <= '0;
    end else if (boundary && (state != ST_INIT)) begin
      slot_cnt <= skp_due ? 8'd0 : slot_cnt + 8'd1;
    end
  end

  assign skp_due = (slot_cnt == 8'(SKP_INTERVAL - 1));
`else
  logic unused_skp;
  assign unused_skp = ^{SKP_SYM, 8'(SKP_INTERVAL)};
  assign skp_due    = 1'b0;
`endif

  // Search starts one past the last grant so every valid lane is reached within NUM_REQ slots.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    cand  = rr_ptr;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = rr_ptr + IDW'(i);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    rr_nxt       = rr_ptr;
    gid_nxt      = grant_id;
    data_nxt     = ser_data;
    valid_nxt    = ser_valid;
    ack_nxt      = '0;
    if (boundary) begin
      data_nxt  = IDLE_SYM;
      valid_nxt = 1'b0;
      if (state == ST_INIT) begin
        init_cnt_nxt = init_cnt + 4'd1;
        if (init_cnt_nxt == 4'(INIT_SLOTS)) state_nxt = ST_IDLE;
      end else if (skp_due) begin
        data_nxt  = SKP_SYM;
        state_nxt = ST_IDLE;
      end else if (found) begin
        data_nxt      = req_data[{pick, 3'b000} +: 8];
        valid_nxt     = 1'b1;
        gid_nxt       = pick;
        rr_nxt        = pick;
        ack_nxt[pick] = 1'b1;
        state_nxt     = ST_ACTIVE;
      end else begin
        state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state      <= ST_INIT;
      bit_cnt    <= '0;
      init_cnt   <= '0;
      rr_ptr     <= '1;
      grant_id   <= '0;
      ser_data   <= IDLE_SYM;
      ser_valid  <= 1'b0;
      req_ack    <= '0;
      slot_start <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt + 3'd1;
      init_cnt   <= init_cnt_nxt;
      rr_ptr     <= rr_nxt;
      grant_id   <= gid_nxt;
      ser_data   <= data_nxt;
      ser_valid  <= valid_nxt;
      req_ack    <= ack_nxt;
      slot_start <= boundary;
    end
  end

endmodule

// File: tb/tb_partoserial_arb.sv
// Self-checking bench for partoserial_arb: table of per-slot requests with expected slot
// outputs pushed to a scoreboard, plus a hand-written mid-slot reset sequence.
module tb_partoserial_arb;

  localparam int W = 11;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        exp_v;
    logic [1:0]  exp_gid;
    logic [7:0]  exp_data;
  } row_t;

  logic        clk_8f    = 1'b0;
  logic        reset     = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_ack;
  logic [7:0]  ser_data;
  logic        ser_valid, slot_start, busy;
  logic [1:0]  grant_id, dbg_state;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  last_data = 8'hBC;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [3:0]  mon_ack;
  row_t        tbl[32];
  int          n_main;

  always #5 clk_8f = ~clk_8f;

  partoserial_arb #(
    .NUM_REQ(4), .INIT_SLOTS(4), .IDLE_SYM(8'hBC), .SKP_SYM(8'h1C), .SKP_INTERVAL(4)
  ) dut (
    .clk_8f(clk_8f), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .ser_data(ser_data), .ser_valid(ser_valid),
    .slot_start(slot_start), .grant_id(grant_id), .busy(busy), .dbg_state(dbg_state)
  );

  // Rising edges since reset release; edge count n leaves bit_cnt == n % 8.
  always @(posedge clk_8f or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: slot outputs are checked against the scoreboard at each slot's first cycle.
  always @(negedge clk_8f) begin
    if (mon_en && reset) begin
      if ((cyc % 8 == 0) && (cyc != 0)) begin
        check("slot_start_hi", 32'(slot_start), 32'd1);
        if (exp_q.size() == 0) begin
          check("sb_unexpected_slot", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_ack = mon_e[10] ? 4'(1 << mon_e[9:8]) : 4'd0;
          check("slot_out", 32'({ser_valid, grant_id, ser_data}), 32'(mon_e));
          check("ack_pulse", 32'(req_ack), 32'(mon_ack));
          check("busy", 32'(busy), 32'(mon_e[10]));
        end
        last_data = ser_data;
      end else begin
        check("slot_start_lo", 32'(slot_start), 32'd0);
        check("ack_low", 32'(req_ack), 32'd0);
        check("data_stable", 32'(ser_data), 32'(last_data));
      end
    end
  end

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    @(negedge clk_8f);
    while ((cyc % 8 != p) && (n < 16)) begin
      @(negedge clk_8f);
      n++;
    end
    check("phase_sync", 32'(cyc % 8), 32'(p));
  endtask

  task automatic apply_row(input int i);
    req_valid = tbl[i].valid;
    req_data  = tbl[i].data;
    exp_q.push_back({tbl[i].exp_v, tbl[i].exp_gid, tbl[i].exp_data});
    wait_phase(3);
  endtask

  task automatic set_row(input int i, input logic [3:0] v, input logic [31:0] d,
                         input logic ev, input logic [1:0] eg, input logic [7:0] ed);
    tbl[i] = '{v, d, ev, eg, ed};
  endtask

  task automatic check_reset_vals();
    check("rst_ser_data", 32'(ser_data), 32'hBC);
    check("rst_ser_valid", 32'(ser_valid), 32'd0);
    check("rst_req_ack", 32'(req_ack), 32'd0);
    check("rst_slot_start", 32'(slot_start), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  task automatic release_reset();
    #2;
    reset     = 1'b1;
    last_data = 8'hBC;
    mon_en    = 1'b1;
    wait_phase(3);
  endtask

  initial begin
`ifdef SKP_INSERT_EN
    for (int i = 0; i < 4; i++) set_row(i, 4'b0001, 32'h13121110, 1'b0, 2'd0, 8'hBC);
    for (int i = 4; i < 12; i++) begin
      if ((i % 4) == 3) set_row(i, 4'b0001, 32'h13121110, 1'b0, 2'd0, 8'h1C);
      else              set_row(i, 4'b0001, 32'h13121110, 1'b1, 2'd0, 8'h10);
    end
    n_main = 12;
`else
    // Lane 2 waits through INIT, then is granted once and drops.
    for (int i = 0; i < 4; i++) set_row(i, 4'b0100, 32'h13A51110, 1'b0, 2'd0, 8'hBC);
    set_row(4,  4'b0100, 32'h13A51110, 1'b1, 2'd2, 8'hA5);
    set_row(5,  4'b0000, $urandom,     1'b0, 2'd2, 8'hBC);
    set_row(6,  4'b0000, $urandom,     1'b0, 2'd2, 8'hBC);
    // All lanes valid: strict rotation from the lane after the last grant.
    set_row(7,  4'b1111, 32'h13121110, 1'b1, 2'd3, 8'h13);
    set_row(8,  4'b1111, 32'h13121110, 1'b1, 2'd0, 8'h10);
    set_row(9,  4'b1111, 32'h13121110, 1'b1, 2'd1, 8'h11);
    set_row(10, 4'b1111, 32'h13121110, 1'b1, 2'd2, 8'h12);
    set_row(11, 4'b1111, 32'h13121110, 1'b1, 2'd3, 8'h13);
    set_row(12, 4'b1111, 32'h13121110, 1'b1, 2'd0, 8'h10);
    // Lanes 1 and 3; lane 1 drops after its ack and later reasserts.
    set_row(13, 4'b1010, 32'h13121110, 1'b1, 2'd1, 8'h11);
    set_row(14, 4'b1000, 32'h13121110, 1'b1, 2'd3, 8'h13);
    set_row(15, 4'b1000, 32'h13121110, 1'b1, 2'd3, 8'h13);
    set_row(16, 4'b1000, 32'h13121110, 1'b1, 2'd3, 8'h13);
    set_row(17, 4'b1010, 32'h13121110, 1'b1, 2'd1, 8'h11);
    set_row(18, 4'b1010, 32'h13121110, 1'b1, 2'd3, 8'h13);
    set_row(19, 4'b0000, $urandom,     1'b0, 2'd3, 8'hBC);
    // Single lane gets every slot back to back; new byte after ack.
    set_row(20, 4'b0001, 32'h13121110, 1'b1, 2'd0, 8'h10);
    set_row(21, 4'b0001, 32'h13121110, 1'b1, 2'd0, 8'h10);
    set_row(22, 4'b0001, 32'h13121110, 1'b1, 2'd0, 8'h10);
    set_row(23, 4'b0001, 32'h1312115A, 1'b1, 2'd0, 8'h5A);
    // After a mid-slot reset: INIT again, then the pending lanes 0 and 2.
    for (int i = 24; i < 28; i++) set_row(i, 4'b0101, 32'h133C7766, 1'b0, 2'd0, 8'hBC);
    set_row(28, 4'b0101, 32'h133C7766, 1'b1, 2'd0, 8'h66);
    set_row(29, 4'b0100, 32'h133C7766, 1'b1, 2'd2, 8'h3C);
    set_row(30, 4'b0000, $urandom,     1'b0, 2'd2, 8'hBC);
    n_main = 24;
`endif

    reset = 1'b0;
    repeat (3) @(negedge clk_8f);
    #1;
    check_reset_vals();
    check("rst_state", 32'(dbg_state), 32'd0);
    release_reset();

    for (int i = 0; i < n_main; i++) apply_row(i);

`ifndef SKP_INSERT_EN
    req_valid = 4'b0010;
    req_data  = 32'h1312775A;
    exp_q.push_back({1'b1, 2'd1, 8'h77});
    wait_phase(3);
    // Lanes 0 and 2 raise new requests, then reset lands at bit_cnt==4 of the active slot.
    req_valid = 4'b0101;
    req_data  = 32'h133C7766;
    wait_phase(4);
    check("pre_reset_state", 32'(dbg_state), 32'd2);
    #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check_reset_vals();
    check("sb_drained_reset", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk_8f);
    release_reset();
    for (int i = 24; i < 31; i++) apply_row(i);
`endif

    check("sb_drained_end", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog timeout");
  end

endmodule
